spi_cmd_sequencer: RTL
======================

Name: spi_cmd_sequencer

Overview:
- Sits between the UART receiver and the SPI master inside the UART data processor.
- Parses ASCII command frames arriving as received bytes and sequences the multi-byte SPI transactions each command needs.
- Holds chip-select across all bytes of one transaction and captures the read-back byte for the seven-segment display path.
- Single owner of the SPI master's start/done handshake.

Parameters:
- OP_READ, 8'h52, opcode 'R': 2 SPI bytes (addr, 8'h00); byte-1 MISO is the result.
- OP_WRITE, 8'h57, opcode 'W': 2 SPI bytes (addr, value); no result.
- ARG_TIMEOUT, 2_500_000, clk cycles (20 ms at 125 MHz) allowed between command bytes before the frame is abandoned.
- SPI_TIMEOUT, 250_000, clk cycles allowed for spi_done per byte.
- CS_GAP, 16, minimum idle clk cycles with spi_hold low between transactions.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- spi_start  out  1  one-cycle request to the SPI master to shift spi_tx_data.
- spi_tx_data  out  8  byte to transmit; stable from spi_start until spi_done.
- spi_hold  out  1  high keeps CS_n asserted between bytes of one transaction.
- spi_busy  in  1  SPI master is shifting.
- spi_done  in  1  one-cycle strobe; spi_rx_data is valid in that cycle.
- spi_rx_data  in  8  byte shifted in on MISO.
- disp_data  out  8  last read result, held until the next read completes.
- disp_valid  out  1  one-cycle strobe when disp_data updates.
- err  out  1  one-cycle strobe on bad opcode or any timeout.
- seq_busy  out  1  high in every state other than IDLE.

Behaviour:
- All registers update on posedge clk only. The synchronous reset has priority over every other input.
- Reset values: spi_start=0, spi_tx_data=0, spi_hold=0, disp_data=0, disp_valid=0, err=0, seq_busy=0. State=IDLE; all counters 0.
- States:
  - IDLE: on rx_valid, if rx_data is OP_READ or OP_WRITE, latch the opcode and go to GET_ADDR. Otherwise pulse err next cycle and stay in IDLE.
  - GET_ADDR: wait for rx_valid, latch addr. On a READ, latch value=8'h00 and go to ISSUE0. On a WRITE, go to GET_VAL.
  - GET_VAL: wait for rx_valid, latch value, go to ISSUE0.
  - Argument timeout: in GET_ADDR and GET_VAL, a counter reloads on entry and on each rx_valid. If it reaches ARG_TIMEOUT, pulse err and go to IDLE.
  - ISSUE0: wait until spi_busy=0. Then assert spi_hold=1, drive spi_tx_data=addr, pulse spi_start for 1 cycle, go to WAIT0.
  - WAIT0: on spi_done go to ISSUE1.
  - ISSUE1: spi_tx_data=value, pulse spi_start, go to WAIT1.
  - WAIT1: on spi_done, deassert spi_hold. On a READ, also latch spi_rx_data into disp_data and pulse disp_valid. Go to GAP.
  - SPI timeout: in WAIT0 and WAIT1, if SPI_TIMEOUT cycles pass without spi_done, drop spi_hold, pulse err and go to GAP.
  - GAP: count CS_GAP cycles with spi_hold=0, then go to IDLE.
- Latency: spi_start goes high 1 cycle after entering ISSUEx when spi_busy=0. disp_valid goes high exactly 1 cycle after the byte-1 spi_done.
- rx_valid arriving in ISSUE0 through GAP is dropped, with no err. The UART side is responsible for pacing.
- spi_done seen outside WAIT0/WAIT1 is ignored.
- If spi_done and the timeout terminal count coincide, spi_done wins.
- rst during a transaction drops spi_hold immediately (the next cycle). No disp_valid follows.
- Counters saturate and do not wrap. Counter widths are derived with $clog2 of the respective parameter.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - the state enum;
  - OP_READ and OP_WRITE constants;
  - the 125 MHz clock-rate constant used to derive timeouts.
- One sub-module, seq_timeout_ctr: a loadable saturating down-counter with a terminal flag.
- seq_timeout_ctr is instantiated twice: once for the argument timeout and once for the SPI timeout plus CS gap, which reuses the counter.

Test Plan:
- READ: rx bytes 0x52, 0x30, with the SPI model returning 0xAA on byte 1. Required: spi_tx_data is 0x30 then 0x00; spi_hold stays high across both bytes; disp_data=0xAA with a single disp_valid.
- WRITE: rx bytes 0x57, 0x12, 0x34. Required: two spi_start pulses with data 0x12 then 0x34; no disp_valid; disp_data keeps its previous value.
- Bad opcode: rx 0x41. Required: one err pulse; state stays IDLE; spi_start is never asserted.
- Argument timeout: rx 0x52 and then nothing for ARG_TIMEOUT+1 cycles. Required: err pulse, return to IDLE. A following valid 0x52, 0x05 then executes normally.
- SPI hang: the SPI model never asserts spi_done. Required: err pulse SPI_TIMEOUT cycles after spi_start; spi_hold falls the same cycle as err; IDLE is reached after CS_GAP more cycles.
- Reset mid-WAIT1: assert rst. Required: all outputs read 0 the next cycle; no disp_valid afterwards; a new READ after reset release succeeds.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the UART-to-SPI command sequencer: opcodes, state encoding
// and the clock rate that default timeouts are derived from.
package spi_cmd_pkg;

  localparam int unsigned CLK_HZ          = 125_000_000;
  localparam int unsigned ARG_TIMEOUT_DEF = CLK_HZ / 50;   // 20 ms
  localparam int unsigned SPI_TIMEOUT_DEF = CLK_HZ / 500;  // 2 ms
  localparam int unsigned CS_GAP_DEF      = 16;

  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_VAL,
    S_ISSUE0,
    S_WAIT0,
    S_ISSUE1,
    S_WAIT1,
    S_GAP
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Loadable down-counter that stops at zero; tc is high while the count is zero.
module seq_timeout_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Parses 'R'/'W' command frames from the UART and runs the two-byte SPI transaction
// for each, holding chip-select across both bytes and capturing read results.
//
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   GET_ADDR | waiting for the address byte (argument timer running)
//   GET_VAL  | waiting for the write value byte (argument timer running)
//   ISSUE0   | waiting for SPI master idle, then start byte 0 (addr)
//   WAIT0    | byte 0 in flight (SPI timer running)
//   ISSUE1   | start byte 1 (value, or 0x00 on a read)
//   WAIT1    | byte 1 in flight (SPI timer running)
//   GAP      | chip-select released, enforcing minimum idle time
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ARG_TIMEOUT = ARG_TIMEOUT_DEF,
  parameter int unsigned SPI_TIMEOUT = SPI_TIMEOUT_DEF,
  parameter int unsigned CS_GAP      = CS_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       spi_start,
  output logic [7:0] spi_tx_data,
  output logic       spi_hold,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx_data,
  output logic [7:0] disp_data,
  output logic       disp_valid,
  output logic       err,
  output logic       seq_busy
);

  localparam int unsigned ARG_W   = $clog2(ARG_TIMEOUT + 1);
  localparam int unsigned TMR_MAX = (SPI_TIMEOUT > CS_GAP) ? SPI_TIMEOUT : CS_GAP;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // Loaded with N-1 so the terminal flag is acted on after exactly N cycles.
  localparam logic [ARG_W-1:0] ARG_LOAD = ARG_W'(ARG_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SPI  = TMR_W'(SPI_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_GAP  = TMR_W'(CS_GAP - 1);

  seq_state_t state_q, state_d;
  logic       is_read_q, is_read_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] val_q, val_d;
  logic       spi_start_q, spi_start_d;
  logic [7:0] spi_tx_q, spi_tx_d;
  logic       spi_hold_q, spi_hold_d;
  logic [7:0] disp_q, disp_d;
  logic       disp_valid_q, disp_valid_d;
  logic       err_q, err_d;

  logic             arg_en, arg_tc;
  logic             tmr_load, tmr_en, tmr_tc;
  logic [TMR_W-1:0] tmr_val;

  seq_timeout_ctr #(.W(ARG_W)) u_arg_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_valid),
    .en       (arg_en),
    .load_val (ARG_LOAD),
    .tc       (arg_tc)
  );

  // Shared between the per-byte SPI timeout and the chip-select gap.
  seq_timeout_ctr #(.W(TMR_W)) u_tmr_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    val_d        = val_q;
    spi_start_d  = 1'b0;
    spi_tx_d     = spi_tx_q;
    spi_hold_d   = spi_hold_q;
    disp_d       = disp_q;
    disp_valid_d = 1'b0;
    err_d        = 1'b0;
    arg_en       = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_val      = TMR_SPI;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
            is_read_d = (rx_data == OP_READ);
            state_d   = S_GET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        arg_en = 1'b1;
        if (rx_valid) begin
          addr_d = rx_data;
          if (is_read_q) begin
            val_d   = 8'h00;
            state_d = S_ISSUE0;
          end else begin
            state_d = S_GET_VAL;
          end
        end else if (arg_tc) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GET_VAL: begin
        arg_en = 1'b1;
        if (rx_valid) begin
          val_d   = rx_data;
          state_d = S_ISSUE0;
        end else if (arg_tc) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ISSUE0: begin
        if (!spi_busy) begin
          spi_hold_d  = 1'b1;
          spi_tx_d    = addr_q;
          spi_start_d = 1'b1;
          tmr_load    = 1'b1;
          state_d     = S_WAIT0;
        end
      end
      S_WAIT0: begin
        tmr_en = 1'b1;
        if (spi_done) begin
          state_d = S_ISSUE1;
        end else if (tmr_tc) begin
          spi_hold_d = 1'b0;
          err_d      = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = TMR_GAP;
          state_d    = S_GAP;
        end
      end
      S_ISSUE1: begin
        spi_tx_d    = val_q;
        spi_start_d = 1'b1;
        tmr_load    = 1'b1;
        state_d     = S_WAIT1;
      end
      S_WAIT1: begin
        tmr_en = 1'b1;
        if (spi_done) begin
          spi_hold_d = 1'b0;
          if (is_read_q) begin
            disp_d       = spi_rx_data;
            disp_valid_d = 1'b1;
          end
          tmr_load = 1'b1;
          tmr_val  = TMR_GAP;
          state_d  = S_GAP;
        end else if (tmr_tc) begin
          spi_hold_d = 1'b0;
          err_d      = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = TMR_GAP;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_read_q    <= 1'b0;
      addr_q       <= 8'h00;
      val_q        <= 8'h00;
      spi_start_q  <= 1'b0;
      spi_tx_q     <= 8'h00;
      spi_hold_q   <= 1'b0;
      disp_q       <= 8'h00;
      disp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      val_q        <= val_d;
      spi_start_q  <= spi_start_d;
      spi_tx_q     <= spi_tx_d;
      spi_hold_q   <= spi_hold_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      err_q        <= err_d;
    end
  end

  assign spi_start   = spi_start_q;
  assign spi_tx_data = spi_tx_q;
  assign spi_hold    = spi_hold_q;
  assign disp_data   = disp_q;
  assign disp_valid  = disp_valid_q;
  assign err         = err_q;
  assign seq_busy    = (state_q != S_IDLE);

endmodule
